hams_sort_block_fifo: RTL and testbench
=======================================

Name: hams_sort_block_fifo

Overview:
Parametrised block FIFO between the bitonic sorter output and the merge-sort input.
- Carries NUM_LANES-wide sorted blocks with a per-block last tag.
- Uses a valid/ready handshake on both sides; the current fixed 4-deep push/pop-on-not-empty buffer has neither.
- Adds almost-full backpressure, occupancy and block counters, a flush, sticky drop detection, and an optional in-block sort-order checker.
- Sits in hams_bitonic_sort_top/hams_merge_sort_top integration, replacing the bare hams_syncfifo instance.

Parameters:
- NUM_LANES, 4, lanes per block (matches NUM_ELEMENTS).
- DATA_WIDTH, 32, bits per lane; unsigned compare key.
- FIFO_DEPTH, 8, blocks stored; power of two, >=2.
- AFULL_THRESH, 6, almost_full asserts when entries >= this value.
- CHECK_ORDER, 1, 1 = instantiate the ascending-order checker; 0 = order_err tied 0.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  synchronous clear of contents, counters and sticky flags
- in_vld  in  1  input block valid
- in_rdy  out  1  input ready; = !full
- in_data  in  NUM_LANES*DATA_WIDTH  block; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_last  in  1  final block of the sort pass
- out_vld  out  1  output block valid (= !empty)
- out_rdy  in  1  consumer ready
- out_data  out  NUM_LANES*DATA_WIDTH  head block
- out_last  out  1  head block last tag
- entries  out  $clog2(FIFO_DEPTH+1)  occupancy
- almost_full  out  1  entries >= AFULL_THRESH
- blk_count  out  16  blocks popped since reset/flush; wraps at 2^16
- pass_done  out  1  one-cycle pulse on pop of a block with last=1
- drop_err  out  1  sticky: in_vld=1 while in_rdy=0
- order_err  out  1  sticky: pushed block has lane[i] > lane[i+1] for some i

Behaviour:
- Reset (rst_n=0 at posedge clk): rd/wr pointers=0, entries=0, out_vld=0, in_rdy=1, almost_full=0, blk_count=0, pass_done=0, drop_err=0, order_err=0. Storage is not cleared; out_data is don't-care while out_vld=0. Reset mid-transfer discards all content.
- flush=1 has the same effect as reset on pointers, counters and flags. It takes priority over push/pop in the same cycle.
- Push = in_vld & in_rdy. Pop = out_vld & out_rdy.
- Storage is a circular array. Pointers are $clog2(FIFO_DEPTH)+1 bits; full/empty is decided by the MSB compare; the lower bits wrap.
- First-word-fall-through: a block pushed at edge N gives out_vld=1 with that data after edge N (visible in cycle N+1). Latency is 1 cycle.
- Simultaneous push and pop: allowed whenever not empty; entries unchanged. When full, in_rdy=0, so push is blocked even if a pop occurs; in_rdy rises the cycle after the pop. There is no combinational in_rdy<-out_rdy path.
- in_vld=1 with in_rdy=0: block not stored; drop_err set next edge and held until reset/flush.
- out_data/out_last hold stable while out_vld=1 and out_rdy=0.
- entries, almost_full and in_rdy are registered-state derived; they update the cycle after the push/pop edge.
- Order checker (CHECK_ORDER=1):
  - Evaluated on in_data at push. It uses NUM_LANES-1 unsigned <= compares; equal keys are legal.
  - order_err is set at the push edge, sticky.
  - It does not affect storage.
- pass_done pulses for exactly 1 cycle after the edge popping the last=1 block. blk_count increments by 1 per pop, including that one.

Decomposition:
- hams_pkg gains typedef sort_block_t (packed array [NUM_LANES-1:0] of logic [DATA_WIDTH-1:0]) and localparam HAMS_BLK_FIFO_DEPTH = 8.
- One sub-module: hams_sort_order_chk. It is combinational over NUM_LANES lanes and outputs a mis-order flag; it is generated only when CHECK_ORDER=1.
- Storage is inline; no RAM macro.

Test Plan:
- Reset then push 3 blocks {1,2,3,4},{5,6,7,8},{9,9,10,11} (last on 3rd) with out_rdy=0:
  - entries 1,2,3 on successive cycles; out_data={1,2,3,4} stable.
  - Then out_rdy=1: 3 pops in order; pass_done on 3rd pop; blk_count=3; order_err=0.
- Fill to 8 with out_rdy=0:
  - almost_full at entries=6; in_rdy=0 at 8.
  - Ninth in_vld gives drop_err=1, entries stays 8.
  - One pop: in_rdy=1 next cycle.
- Steady state: push every cycle, out_rdy=1 every cycle, 20 blocks:
  - entries stays 1 after the first cycle.
  - Data emerges 1 cycle after push, in order, through pointer wrap.
- Push {4,3,2,1}: order_err=1 next cycle, block still delivered unchanged. Push {7,7,7,7}: no new error.
- Mid-stream with 5 entries, assert flush=1 together with in_vld=1 and out_rdy=1: next cycle entries=0, out_vld=0, blk_count=0, sticky flags cleared.
- rst_n=0 for one cycle with 4 entries and drop_err=1: all outputs return to reset values; a subsequent push of {0,0,0,1} appears 1 cycle later.

Source files
------------

// File: rtl/hams_pkg.sv
// Shared types and sizing constants for the HAMS bitonic/merge sort datapath.
package hams_pkg;

   localparam int unsigned HAMS_NUM_LANES      = 4;
   localparam int unsigned HAMS_DATA_WIDTH     = 32;
   localparam int unsigned HAMS_BLK_FIFO_DEPTH = 8;

   // Lane 0 occupies the least significant DATA_WIDTH bits of a block.
   typedef logic [HAMS_NUM_LANES-1:0][HAMS_DATA_WIDTH-1:0] sort_block_t;

endpackage

// File: rtl/hams_sort_order_chk.sv
// Combinational ascending-order check across the lanes of one sorted block.
module hams_sort_order_chk
   import hams_pkg::*;
#(
   parameter int unsigned NUM_LANES  = HAMS_NUM_LANES,
   parameter int unsigned DATA_WIDTH = HAMS_DATA_WIDTH
) (
   input  logic [NUM_LANES*DATA_WIDTH-1:0] blk_data,
   output logic                            mis_order
);

   // Equal neighbouring keys are legal; only a strict decrease is flagged.
   always_comb begin
      mis_order = 1'b0;
      for (int i = 0; i < int'(NUM_LANES) - 1; i++) begin
         if (blk_data[i*DATA_WIDTH +: DATA_WIDTH] > blk_data[(i+1)*DATA_WIDTH +: DATA_WIDTH]) begin
            mis_order = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hams_sort_block_fifo.sv
// First-word-fall-through block FIFO between the bitonic sorter and the merge sorter,
// with backpressure, occupancy/block counters, flush and sticky error flags.
module hams_sort_block_fifo
   import hams_pkg::*;
#(
   parameter int unsigned NUM_LANES    = HAMS_NUM_LANES,
   parameter int unsigned DATA_WIDTH   = HAMS_DATA_WIDTH,
   parameter int unsigned FIFO_DEPTH   = HAMS_BLK_FIFO_DEPTH,
   parameter int unsigned AFULL_THRESH = 6,
   parameter int unsigned CHECK_ORDER  = 1
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               flush,
   input  logic                               in_vld,
   output logic                               in_rdy,
   input  logic [NUM_LANES*DATA_WIDTH-1:0]    in_data,
   input  logic                               in_last,
   output logic                               out_vld,
   input  logic                               out_rdy,
   output logic [NUM_LANES*DATA_WIDTH-1:0]    out_data,
   output logic                               out_last,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    entries,
   output logic                               almost_full,
   output logic [15:0]                        blk_count,
   output logic                               pass_done,
   output logic                               drop_err,
   output logic                               order_err
);

   localparam int unsigned BW = NUM_LANES * DATA_WIDTH;
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned EW = $clog2(FIFO_DEPTH + 1);

   logic [BW-1:0]         mem_q [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] last_q;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [15:0]   blk_count_q, blk_count_d;
   logic          pass_done_q, pass_done_d;
   logic          drop_err_q, drop_err_d;
   logic          order_err_q, order_err_d;

   logic          full, empty, push, pop, mis_order;
   logic [PW-1:0] ptr_diff;

   // The extra pointer MSB separates full (wrapped once more) from empty.
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign ptr_diff = wr_ptr_q - rd_ptr_q;

   assign push = in_vld & ~full & ~flush;
   assign pop  = out_rdy & ~empty & ~flush;

   generate
      if (CHECK_ORDER != 0) begin : g_order_chk
         hams_sort_order_chk #(
            .NUM_LANES (NUM_LANES),
            .DATA_WIDTH(DATA_WIDTH)
         ) u_order_chk (
            .blk_data (in_data),
            .mis_order(mis_order)
         );
      end else begin : g_no_order_chk
         assign mis_order = 1'b0;
      end
   endgenerate

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      blk_count_d = blk_count_q;
      pass_done_d = 1'b0;
      drop_err_d  = drop_err_q;
      order_err_d = order_err_q;
      if (flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         blk_count_d = '0;
         drop_err_d  = 1'b0;
         order_err_d = 1'b0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (mis_order) begin
               order_err_d = 1'b1;
            end
         end
         if (pop) begin
            rd_ptr_d    = rd_ptr_q + PW'(1);
            blk_count_d = blk_count_q + 16'd1;
            pass_done_d = last_q[rd_ptr_q[AW-1:0]];
         end
         if (in_vld && full) begin
            drop_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         blk_count_q <= '0;
         pass_done_q <= 1'b0;
         drop_err_q  <= 1'b0;
         order_err_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         blk_count_q <= blk_count_d;
         pass_done_q <= pass_done_d;
         drop_err_q  <= drop_err_d;
         order_err_q <= order_err_d;
      end
   end

   // Block storage is deliberately left out of reset; the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]]  <= in_data;
         last_q[wr_ptr_q[AW-1:0]] <= in_last;
      end
   end

   assign in_rdy      = ~full;
   assign out_vld     = ~empty;
   assign out_data    = mem_q[rd_ptr_q[AW-1:0]];
   assign out_last    = last_q[rd_ptr_q[AW-1:0]];
   assign entries     = EW'(ptr_diff);
   assign almost_full = (ptr_diff >= PW'(AFULL_THRESH));
   assign blk_count   = blk_count_q;
   assign pass_done   = pass_done_q;
   assign drop_err    = drop_err_q;
   assign order_err   = order_err_q;

endmodule

// File: tb/tb_hams_sort_block_fifo.sv
// Self-checking bench for hams_sort_block_fifo: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_hams_sort_block_fifo;

   localparam int NL    = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 8;
   localparam int AFT   = 6;
   localparam int BW    = NL * DW;

   typedef logic [NL-1:0][DW-1:0] blk_t;

   typedef struct {
      logic        rstn;
      logic        fl;
      logic        iv;
      logic        il;
      logic        ordy;
      int unsigned l0, l1, l2, l3;
      int          exp_entries;
      logic        exp_out_vld;
      int unsigned exp_head0;
      logic        exp_pass;
      int          exp_blk;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n, flush, in_vld, in_rdy, in_last;
   logic          out_vld, out_rdy, out_last;
   logic [BW-1:0] in_data, out_data;
   logic [3:0]    entries;
   logic          almost_full, pass_done, drop_err, order_err;
   logic [15:0]   blk_count;

   int checks = 0;
   int errors = 0;

   blk_t m_data[$];
   bit   m_last[$];
   int   m_count;
   bit   m_pass, m_drop, m_order;

   vec_t vecs[8];

   always #5 clk = ~clk;

   hams_sort_block_fifo #(
      .NUM_LANES   (NL),
      .DATA_WIDTH  (DW),
      .FIFO_DEPTH  (DEPTH),
      .AFULL_THRESH(AFT),
      .CHECK_ORDER (1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_vld     (in_vld),
      .in_rdy     (in_rdy),
      .in_data    (in_data),
      .in_last    (in_last),
      .out_vld    (out_vld),
      .out_rdy    (out_rdy),
      .out_data   (out_data),
      .out_last   (out_last),
      .entries    (entries),
      .almost_full(almost_full),
      .blk_count  (blk_count),
      .pass_done  (pass_done),
      .drop_err   (drop_err),
      .order_err  (order_err)
   );

   function automatic blk_t mkBlk(input int unsigned a, input int unsigned b,
                                  input int unsigned c, input int unsigned d);
      blk_t r;
      r[0] = a;
      r[1] = b;
      r[2] = c;
      r[3] = d;
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference behaviour: a bounded queue of blocks plus counters and sticky flags.
   task automatic modelStep(input logic rst, input logic fl, input logic iv,
                            input logic il, input logic ordy, input blk_t d);
      bit was_full;
      was_full = (m_data.size() == DEPTH);
      if (!rst || fl) begin
         m_data.delete();
         m_last.delete();
         m_count = 0;
         m_pass  = 0;
         m_drop  = 0;
         m_order = 0;
         return;
      end
      m_pass = 0;
      if (ordy && m_data.size() > 0) begin
         m_pass = m_last[0];
         void'(m_data.pop_front());
         void'(m_last.pop_front());
         m_count = (m_count + 1) % 65536;
      end
      if (iv && was_full) m_drop = 1;
      if (iv && !was_full) begin
         m_data.push_back(d);
         m_last.push_back(il);
         for (int i = 0; i < NL - 1; i++) begin
            if (d[i] > d[i+1]) m_order = 1;
         end
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic fl, input logic iv,
                                input logic il, input logic ordy, input blk_t d);
      rst_n   = rst;
      flush   = fl;
      in_vld  = iv;
      in_last = il;
      out_rdy = ordy;
      in_data = d;
      @(posedge clk);
      modelStep(rst, fl, iv, il, ordy, d);
      #1;
   endtask

   task automatic checkModel(input string tag);
      checkOutput({tag, "_entries"},   BW'(entries),     BW'(m_data.size()));
      checkOutput({tag, "_in_rdy"},    BW'(in_rdy),      BW'(m_data.size() < DEPTH));
      checkOutput({tag, "_out_vld"},   BW'(out_vld),     BW'(m_data.size() > 0));
      checkOutput({tag, "_afull"},     BW'(almost_full), BW'(m_data.size() >= AFT));
      checkOutput({tag, "_blk_count"}, BW'(blk_count),   BW'(m_count));
      checkOutput({tag, "_pass_done"}, BW'(pass_done),   BW'(m_pass));
      checkOutput({tag, "_drop_err"},  BW'(drop_err),    BW'(m_drop));
      checkOutput({tag, "_order_err"}, BW'(order_err),   BW'(m_order));
      if (m_data.size() > 0) begin
         checkOutput({tag, "_out_data"}, out_data,      m_data[0]);
         checkOutput({tag, "_out_last"}, BW'(out_last), BW'(m_last[0]));
      end
   endtask

   task automatic doReset();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
   endtask

   task automatic fillTo(input int n);
      for (int k = 1; k <= n; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, mkBlk(k, k, k + 1, k + 2));
      end
   endtask

   initial begin
      blk_t b;
      logic rst, fl, iv, il, ordy;
      int unsigned prev;

      rst_n = 1'b0; flush = 1'b0; in_vld = 1'b0; in_last = 1'b0; out_rdy = 1'b0; in_data = '0;

      // Three blocks held back, then drained; lane 0 of the head identifies each block.
      vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0,    0, 1'b0, 0, 1'b0, 0};
      vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 2, 3, 4,    1, 1'b1, 1, 1'b0, 0};
      vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5, 6, 7, 8,    2, 1'b1, 1, 1'b0, 0};
      vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 9, 9, 10, 11,  3, 1'b1, 1, 1'b0, 0};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0,    2, 1'b1, 5, 1'b0, 1};
      vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0,    1, 1'b1, 9, 1'b0, 2};
      vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0,    0, 1'b0, 0, 1'b1, 3};
      vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0,    0, 1'b0, 0, 1'b0, 3};

      for (int v = 0; v < 8; v++) begin
         applyStimulus(vecs[v].rstn, vecs[v].fl, vecs[v].iv, vecs[v].il, vecs[v].ordy,
                       mkBlk(vecs[v].l0, vecs[v].l1, vecs[v].l2, vecs[v].l3));
         checkOutput("tbl_entries", BW'(entries),   BW'(vecs[v].exp_entries));
         checkOutput("tbl_out_vld", BW'(out_vld),   BW'(vecs[v].exp_out_vld));
         if (vecs[v].exp_out_vld) begin
            checkOutput("tbl_head0", BW'(out_data[DW-1:0]), BW'(vecs[v].exp_head0));
         end
         checkOutput("tbl_pass_done", BW'(pass_done), BW'(vecs[v].exp_pass));
         checkOutput("tbl_blk_count", BW'(blk_count), BW'(vecs[v].exp_blk));
         checkOutput("tbl_order_err", BW'(order_err), BW'(1'b0));
         checkModel("tbl");
      end

      $display("[TB] fill to full, overflow, pop while full");
      doReset();
      for (int k = 1; k <= DEPTH; k++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, mkBlk(k, k, k + 1, k + 2));
         checkOutput("fill_entries", BW'(entries),     BW'(k));
         checkOutput("fill_afull",   BW'(almost_full), BW'(k >= AFT));
         checkOutput("fill_in_rdy",  BW'(in_rdy),      BW'(k < DEPTH));
         checkModel("fill");
      end
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, mkBlk(99, 99, 99, 99));
      checkOutput("ovf_drop_err", BW'(drop_err), BW'(1'b1));
      checkOutput("ovf_entries",  BW'(entries),  BW'(DEPTH));
      checkModel("ovf");
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, mkBlk(50, 51, 52, 53));
      checkOutput("fullpop_entries", BW'(entries), BW'(DEPTH - 1));
      checkOutput("fullpop_in_rdy",  BW'(in_rdy),  BW'(1'b1));
      checkOutput("fullpop_head0",   BW'(out_data[DW-1:0]), BW'(2));
      checkModel("fullpop");

      $display("[TB] steady-state streaming through pointer wrap");
      doReset();
      for (int i = 0; i < 20; i++) begin
         b = mkBlk(100 + 4*i, 101 + 4*i, 102 + 4*i, 103 + 4*i);
         applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, b);
         checkOutput("stream_entries", BW'(entries), BW'(1));
         checkOutput("stream_data",    out_data,     b);
         checkModel("stream");
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0);
      checkOutput("stream_blk_count", BW'(blk_count), BW'(20));
      checkModel("stream_end");

      $display("[TB] order checker");
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, mkBlk(7, 7, 7, 7));
      checkOutput("ord_equal_ok", BW'(order_err), BW'(1'b0));
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, mkBlk(4, 3, 2, 1));
      checkOutput("ord_bad_set", BW'(order_err), BW'(1'b1));
      checkModel("ord");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0);
      checkOutput("ord_bad_data", out_data, mkBlk(4, 3, 2, 1));
      checkOutput("ord_sticky",   BW'(order_err), BW'(1'b1));
      checkModel("ord_pop");

      $display("[TB] flush with concurrent push and pop");
      doReset();
      for (int i = 0; i < 5; i++) begin
         b = (i == 2) ? mkBlk(9, 1, 2, 3) : mkBlk(i, i + 1, i + 2, i + 3);
         applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, b);
      end
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, mkBlk(20, 21, 22, 23));
      checkOutput("preflush_entries", BW'(entries),   BW'(5));
      checkOutput("preflush_blk",     BW'(blk_count), BW'(1));
      checkOutput("preflush_order",   BW'(order_err), BW'(1'b1));
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, mkBlk(1, 2, 3, 4));
      checkOutput("flush_entries", BW'(entries),   BW'(0));
      checkOutput("flush_out_vld", BW'(out_vld),   BW'(1'b0));
      checkOutput("flush_blk",     BW'(blk_count), BW'(0));
      checkOutput("flush_order",   BW'(order_err), BW'(1'b0));
      checkOutput("flush_drop",    BW'(drop_err),  BW'(1'b0));
      checkModel("flush");

      $display("[TB] reset while holding data and a drop error");
      doReset();
      fillTo(DEPTH);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, mkBlk(77, 77, 77, 77));
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0);
      checkOutput("prerst_entries", BW'(entries),  BW'(4));
      checkOutput("prerst_drop",    BW'(drop_err), BW'(1'b1));
      doReset();
      checkOutput("rst_entries", BW'(entries),     BW'(0));
      checkOutput("rst_out_vld", BW'(out_vld),     BW'(1'b0));
      checkOutput("rst_in_rdy",  BW'(in_rdy),      BW'(1'b1));
      checkOutput("rst_afull",   BW'(almost_full), BW'(1'b0));
      checkOutput("rst_blk",     BW'(blk_count),   BW'(0));
      checkOutput("rst_pass",    BW'(pass_done),   BW'(1'b0));
      checkOutput("rst_drop",    BW'(drop_err),    BW'(1'b0));
      checkOutput("rst_order",   BW'(order_err),   BW'(1'b0));
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, mkBlk(0, 0, 0, 1));
      checkOutput("postrst_vld",  BW'(out_vld), BW'(1'b1));
      checkOutput("postrst_data", out_data,     mkBlk(0, 0, 0, 1));
      checkModel("postrst");

      $display("[TB] randomized traffic");
      doReset();
      for (int n = 0; n < 600; n++) begin
         rst  = ($urandom_range(0, 149) != 0);
         fl   = ($urandom_range(0, 79) == 0);
         iv   = ($urandom_range(0, 3) != 0);
         il   = ($urandom_range(0, 4) == 0);
         ordy = ((n / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         prev = $urandom_range(0, 15);
         for (int i = 0; i < NL; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               b[i] = $urandom_range(0, 31);
            end else begin
               b[i] = prev;
            end
            prev = prev + $urandom_range(0, 3);
         end
         applyStimulus(rst, fl, iv, il, ordy, b);
         checkModel("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
